// File: rtl/invader_row_scheduler_pkg.sv
// Shared constants for the invader formation: sprite enums, row-to-sprite mapping,
// formation width and screen resolution.
package invader_row_scheduler_pkg;

    localparam int INVADERS_H = 11;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    // Base frames are even so the animation bit can be OR'd into the LSB.
    typedef enum logic [2:0] {
        INVADER1     = 3'd0,
        INVADER1_ALT = 3'd1,
        INVADER2     = 3'd2,
        INVADER2_ALT = 3'd3,
        INVADER3     = 3'd4,
        INVADER3_ALT = 3'd5
    } sprite_e;

    function automatic sprite_e row_sprite_base(input logic [2:0] row);
        case (row)
            3'd0:       return INVADER1;
            3'd1, 3'd2: return INVADER2;
            default:    return INVADER3;
        endcase
    endfunction

endpackage

// File: rtl/invader_row_scheduler_march.sv
// formation_march: frame divider, march direction and formation origin.
// With INVADER_ANIM_EN defined it also owns the animation bit toggled per step.
module formation_march #(
    parameter int START_X  = 40,
    parameter int START_Y  = 60,
    parameter int X_MIN    = 8,
    parameter int X_MAX    = 200,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 8,
    parameter int MOVE_DIV = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    output logic [9:0] form_x,
    output logic [9:0] form_y
`ifdef INVADER_ANIM_EN
    ,
    output logic       anim
`endif
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CNT_W-1:0] frame_cnt;
    logic             dir_left;
    logic             step;
    logic [10:0]      cand;
    logic             in_range;

    // 11-bit candidate so a step past either edge (including below zero) reads out of range
    assign step     = update && (frame_cnt == CNT_W'(MOVE_DIV - 1));
    assign cand     = dir_left ? ({1'b0, form_x} - 11'(STEP_X)) : ({1'b0, form_x} + 11'(STEP_X));
    assign in_range = (cand >= 11'(X_MIN)) && (cand <= 11'(X_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            form_x    <= 10'(START_X);
            form_y    <= 10'(START_Y);
            dir_left  <= 1'b0;
            frame_cnt <= '0;
`ifdef INVADER_ANIM_EN
            anim      <= 1'b0;
`endif
        end else if (update) begin
            if (step) begin
                frame_cnt <= '0;
                if (in_range) begin
                    form_x <= cand[9:0];
                end else begin
                    form_y   <= form_y + 10'(STEP_Y);
                    dir_left <= !dir_left;
                end
`ifdef INVADER_ANIM_EN
                anim <= !anim;
`endif
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/invader_row_scheduler.sv
// Frame-level sequencer for the shared sprite-row drawer: issues one row_start per row,
// owns the alive bitmap and kill handling. INVADER_ANIM_EN adds the animation bit to row_sprite.
module invader_row_scheduler #(
    parameter int NUM_ROWS   = 5,
    parameter int INVADERS_H = invader_row_scheduler_pkg::INVADERS_H,
    parameter int ROW_PITCH  = 24,
    parameter int ROW_LINES  = 16,
    parameter int ISSUE_X    = 0,
    parameter int START_X    = 40,
    parameter int START_Y    = 60,
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 200,
    parameter int STEP_X     = 2,
    parameter int STEP_Y     = 8,
    parameter int MOVE_DIV   = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  kill_valid,
    input  logic [2:0]            kill_row,
    input  logic [3:0]            kill_col,
    output logic                  kill_ack,
    output logic                  row_start,
    output logic [2:0]            row_sprite,
    output logic [9:0]            row_x,
    output logic [INVADERS_H-1:0] row_sprites,
    output logic [2:0]            row_idx,
    output logic [9:0]            form_x,
    output logic [9:0]            form_y,
    output logic                  all_dead
);

    import invader_row_scheduler_pkg::*;

    typedef enum logic [2:0] {IDLE, WAIT_LINE, ISSUE, BUSY, UPDATE} state_e;

    state_e                state;
    logic [2:0]            cur_row;
    logic                  update;
    logic [INVADERS_H-1:0] alive [NUM_ROWS];
    logic [10:0]           row_top;
    logic [10:0]           row_end;
    logic                  line_hit;
    logic                  row_end_hit;
    logic                  kill_ok;
    logic                  any_alive;
`ifdef INVADER_ANIM_EN
    logic                  anim;
`endif

    assign row_top     = {1'b0, form_y} + 11'(cur_row) * 11'(ROW_PITCH);
    assign row_end     = row_top + 11'(ROW_LINES);
    assign line_hit    = ({1'b0, pixel_y} == row_top) && (pixel_x == 10'(ISSUE_X));
    assign row_end_hit = ({1'b0, pixel_y} == row_end);
    assign kill_ok     = kill_valid && (kill_row < 3'(NUM_ROWS)) && (kill_col < 4'(INVADERS_H));

    always_comb begin
        any_alive = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) any_alive = any_alive | (|alive[r]);
    end

    formation_march #(
        .START_X(START_X), .START_Y(START_Y), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .MOVE_DIV(MOVE_DIV)
    ) u_march (
        .clk(clk),
        .rst(rst),
        .update(update),
        .form_x(form_x),
        .form_y(form_y)
`ifdef INVADER_ANIM_EN
        ,
        .anim(anim)
`endif
    );

    // Row fields are captured on entry to ISSUE and held, so a kill mid-row leaves the drawn row stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_row     <= '0;
            update      <= 1'b0;
            row_start   <= 1'b0;
            row_idx     <= '0;
            row_x       <= 10'(START_X);
            row_sprites <= '1;
            row_sprite  <= 3'(row_sprite_base(3'd0));
        end else begin
            row_start <= 1'b0;
            update    <= 1'b0;
            if (frame_start && state != IDLE) begin
                state   <= WAIT_LINE;
                cur_row <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            cur_row <= '0;
                            state   <= WAIT_LINE;
                        end
                    end
                    WAIT_LINE: begin
                        if (row_top >= 11'(SCREEN_H)) begin
                            state  <= UPDATE;
                            update <= 1'b1;
                        end else if (line_hit) begin
                            state       <= ISSUE;
                            row_start   <= 1'b1;
                            row_idx     <= cur_row;
                            row_x       <= form_x;
                            row_sprites <= alive[cur_row];
`ifdef INVADER_ANIM_EN
                            row_sprite  <= 3'(row_sprite_base(cur_row)) | {2'b00, anim};
`else
                            row_sprite  <= 3'(row_sprite_base(cur_row));
`endif
                        end
                    end
                    ISSUE: state <= BUSY;
                    BUSY: begin
                        if (row_end_hit) begin
                            if (cur_row == 3'(NUM_ROWS - 1)) begin
                                state  <= UPDATE;
                                update <= 1'b1;
                            end else begin
                                cur_row <= cur_row + 3'd1;
                                state   <= WAIT_LINE;
                            end
                        end
                    end
                    UPDATE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Kill path: ack and bit clear land together; all_dead trails the bitmap by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_ROWS; r++) alive[r] <= '1;
            kill_ack <= 1'b0;
            all_dead <= 1'b0;
        end else begin
            kill_ack <= kill_ok;
            all_dead <= !any_alive;
            if (kill_ok) alive[kill_row][kill_col] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_invader_row_scheduler.sv
// Randomized bench for invader_row_scheduler against a frame/row-level reference model.
// Honours INVADER_ANIM_EN the same way as the design build.
module tb_invader_row_scheduler;
    import invader_row_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        kill_valid = 1'b0;
    logic [2:0]  kill_row = '0;
    logic [3:0]  kill_col = '0;
    logic        kill_ack;
    logic        row_start;
    logic [2:0]  row_sprite;
    logic [9:0]  row_x;
    logic [10:0] row_sprites;
    logic [2:0]  row_idx;
    logic [9:0]  form_x;
    logic [9:0]  form_y;
    logic        all_dead;

    int n_checks = 0;
    int n_errors = 0;
    int rs_total = 0;

    // Reference model state
    logic [10:0] m_alive [5];
    logic [10:0] obs_mask [5];
    int m_fx, m_fy, m_frames, m_steps;
    bit m_dir_left, m_anim;

    invader_row_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
        .kill_ack(kill_ack), .row_start(row_start), .row_sprite(row_sprite),
        .row_x(row_x), .row_sprites(row_sprites), .row_idx(row_idx),
        .form_x(form_x), .form_y(form_y), .all_dead(all_dead)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && row_start) rs_total++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_sprite(input int r);
        logic [2:0] b;
        b = (r == 0) ? 3'(INVADER1) : ((r < 3) ? 3'(INVADER2) : 3'(INVADER3));
`ifdef INVADER_ANIM_EN
        b[0] = m_anim;
`endif
        return b;
    endfunction

    function automatic bit model_all_dead();
        for (int r = 0; r < 5; r++) if (m_alive[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 5; r++) m_alive[r] = 11'h7FF;
        m_fx = 40; m_fy = 60; m_dir_left = 0; m_anim = 0; m_frames = 0; m_steps = 0;
    endtask

    // One completed frame: every MOVE_DIV-th frame the formation marches or bounces.
    task automatic model_update();
        int cand;
        m_frames++;
        if (m_frames % 30 == 0) begin
            m_steps++;
            m_anim = !m_anim;
            cand = m_dir_left ? m_fx - 2 : m_fx + 2;
            if (cand < 8 || cand > 200) begin
                m_fy += 8;
                m_dir_left = !m_dir_left;
            end else begin
                m_fx = cand;
            end
        end
    endtask

    task automatic park();
        pixel_y = 10'd1000;
        pixel_x = 10'd5;
    endtask

    task automatic check_reset();
        check_val("rst_row_start", row_start, 0);
        check_val("rst_kill_ack", kill_ack, 0);
        check_val("rst_row_idx", row_idx, 0);
        check_val("rst_row_sprites", row_sprites, 11'h7FF);
        check_val("rst_row_x", row_x, 40);
        check_val("rst_form_x", form_x, 40);
        check_val("rst_form_y", form_y, 60);
        check_val("rst_all_dead", all_dead, 0);
        check_val("rst_row_sprite", row_sprite, 3'(INVADER1));
    endtask

    task automatic kill_one(input int r, input int c);
        bit ok;
        ok = (r < 5) && (c < 11);
        kill_valid = 1'b1; kill_row = 3'(r); kill_col = 4'(c);
        tick();
        kill_valid = 1'b0;
        check_val("kill_ack", kill_ack, ok);
        if (ok) m_alive[r][c] = 1'b0;
        tick();
        check_val("ack_pulse", kill_ack, 0);
        check_val("all_dead", all_dead, model_all_dead());
    endtask

    task automatic do_row(input int r, input bit busy_kill);
        int top, c;
        logic [10:0] held;
        top = m_fy + r * 24;
        pixel_y = 10'(top); pixel_x = 10'd0;
        tick();
        check_val("row_start", row_start, 1);
        check_val("row_idx", row_idx, r);
        check_val("row_x", row_x, m_fx);
        check_val("row_sprites", row_sprites, m_alive[r]);
        check_val("row_sprite", row_sprite, exp_sprite(r));
        held = m_alive[r];
        obs_mask[r] = row_sprites;
        pixel_x = 10'd1;
        tick();
        check_val("rs_one_cycle", row_start, 0);
        if (busy_kill) begin
            c = $urandom_range(0, 10);
            kill_valid = 1'b1; kill_row = 3'(r); kill_col = 4'(c);
            tick();
            kill_valid = 1'b0;
            check_val("busy_ack", kill_ack, 1);
            m_alive[r][c] = 1'b0;
            check_val("busy_hold", row_sprites, held);
        end
        pixel_y = 10'(top + 16); pixel_x = 10'd3;
        tick();
        if (busy_kill) check_val("busy_hold2", row_sprites, held);
    endtask

    task automatic do_frame(input bit abort, input bit busy_kill);
        int base, r_kill;
        base = rs_total;
        park();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (abort) begin
            do_row(0, 0);
            do_row(1, 0);
            pixel_y = 10'(m_fy + 48); pixel_x = 10'd0;
            tick();
            check_val("abort_rs", row_start, 1);
            pixel_x = 10'd1;
            tick();
            park();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        r_kill = busy_kill ? int'($urandom_range(0, 4)) : 5;
        for (int r = 0; r < 5; r++) do_row(r, r == r_kill);
        park();
        tick();
        model_update();
        check_val("rs_count", rs_total - base, abort ? 8 : 5);
        check_val("form_x", form_x, m_fx);
        check_val("form_y", form_y, m_fy);
    endtask

    // Raster-like sweep: row_start must appear only on the row-top lines at pixel_x 0
    task automatic sweep_frame();
        int e;
        bit exp;
        e = 0;
        park();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int y = 0; y < 200; y++) begin
            for (int x = 0; x < 3; x++) begin
                pixel_y = 10'(y); pixel_x = 10'(x);
                tick();
                exp = (x == 0) && (e < 5) && (y == 60 + e * 24);
                check_val("sweep_rs", row_start, exp);
                if (exp) begin
                    check_val("sweep_idx", row_idx, e);
                    check_val("sweep_x", row_x, 40);
                    check_val("sweep_mask", row_sprites, 11'h7FF);
                    check_val("sweep_sprite", row_sprite, exp_sprite(e));
                    e++;
                end
            end
        end
        park();
        tick();
        model_update();
        check_val("sweep_rows", e, 5);
        check_val("sweep_form_x", form_x, m_fx);
    endtask

    initial begin
        int prev, frames, base;
        model_reset();
        park();
        repeat (3) tick();
        check_reset();
        rst = 1'b1;
        tick();

        sweep_frame();
        kill_one(2, 3);
        do_frame(0, 0);
        check_val("kill23_mask", obs_mask[2], 11'h7F7);
        do_frame(1, 0);
        do_frame(0, 1);

        frames = 0;
        while (m_steps < 82 && frames < 3000) begin
            prev = m_steps;
            if ($urandom_range(0, 7) == 0) kill_one($urandom_range(0, 7), $urandom_range(0, 15));
            do_frame(0, $urandom_range(0, 15) == 0);
            frames++;
            if (m_steps != prev) begin
                case (m_steps)
                    1: check_val("march30_x", form_x, 42);
                    81: begin
                        check_val("bounce_x", form_x, 200);
                        check_val("bounce_y", form_y, 68);
                    end
                    82: check_val("after_bounce_x", form_x, 198);
                    default: ;
                endcase
            end
        end
        check_val("march_budget", m_steps, 82);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 11; c++) kill_one(r, c);
        check_val("all_dead_final", all_dead, 1);
        kill_one(5, 0);
        kill_one(0, 11);

        // Reset while row 3 is being drawn
        park();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int r = 0; r < 3; r++) do_row(r, 0);
        pixel_y = 10'(m_fy + 72); pixel_x = 10'd0;
        tick();
        check_val("row3_rs", row_start, 1);
        pixel_x = 10'd1;
        tick();
        rst = 1'b0;
        #1;
        check_reset();
        tick();
        rst = 1'b1;
        model_reset();
        base = rs_total;
        pixel_y = 10'd60; pixel_x = 10'd0;
        repeat (4) tick();
        pixel_y = 10'd84;
        repeat (2) tick();
        check_val("no_rs_before_fs", rs_total - base, 0);
        do_frame(0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
